// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO. Frame format and baud divisor are
// sampled when a byte is popped, so they stay fixed for the whole frame.
module uart_tx_fifo #(
   parameter int DIV_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        PCLK,
   input  logic                        PRESETn,
   input  logic [DIV_W-1:0]            cfg_div,
   input  logic [1:0]                  cfg_dbits,
   input  logic [1:0]                  cfg_parity,
   input  logic                        cfg_stop2,
   input  logic                        wr_en,
   input  logic [7:0]                  wr_data,
   output logic                        fifo_full,
   output logic                        fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        ovf,
   output logic                        tx_busy,
   output logic                        tx_done,
   output logic                        tx_serial,
   output logic [2:0]                  dbg_state
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   // Write side: wr_en is a strobe with no back-pressure; a strobe seen while
   // the current level is full is dropped and reported one cycle later on ovf.
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   level_q;
   logic          ovf_q;
   logic          push, pop, load;

   assign fifo_full  = (level_q == (AW+1)'(FIFO_DEPTH));
   assign fifo_empty = (level_q == '0);
   assign fifo_level = level_q;
   assign ovf        = ovf_q;
   assign push       = wr_en & ~fifo_full;

   always_ff @(posedge PCLK) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + (AW+1)'(1);
            2'b01:   level_q <= level_q - (AW+1)'(1);
            default: level_q <= level_q;
         endcase
         ovf_q <= wr_en & fifo_full;
      end
   end

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
   logic [1:0]       dbits_q, dbits_d, parity_q, parity_d;
   logic             stop2_q, stop2_d, par_bit_q, par_bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic             tx_q, tx_d, done_q, done_d;
   logic [7:0]       head, head_mask;
   logic             head_xor, head_par, bit_end;

   // Parity is computed from the head entry at pop time, before shifting.
   assign head      = mem_q[rd_ptr_q];
   assign head_mask = 8'hFF >> (2'd3 - cfg_dbits);
   assign head_xor  = ^(head & head_mask);
   assign bit_end   = (cnt_q == div_q - DIV_W'(1));

   always_comb begin
      case (cfg_parity)
         2'b01:   head_par = head_xor;
         2'b10:   head_par = ~head_xor;
         default: head_par = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      cnt_d     = cnt_q;
      dbits_d   = dbits_q;
      parity_d  = parity_q;
      stop2_d   = stop2_q;
      par_bit_d = par_bit_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = tx_q;
      done_d    = 1'b0;
      pop       = 1'b0;
      load      = 1'b0;
      if (state_q != S_IDLE) cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) load = 1'b1;
         end
         S_START: begin
            if (bit_end) begin
               state_d   = S_DATA;
               tx_d      = shreg_q[0];
               bit_cnt_d = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == {1'b1, dbits_q}) begin
                  bit_cnt_d = '0;
                  if (parity_q != 2'b00) begin
                     state_d = S_PARITY;
                     tx_d    = par_bit_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  shreg_d   = shreg_q >> 1;
                  tx_d      = shreg_q[1];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d   = S_STOP;
               tx_d      = 1'b1;
               bit_cnt_d = '0;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (bit_cnt_q[0] == stop2_q) begin
                  done_d = 1'b1;
                  if (!fifo_empty) begin
                     load = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (load) begin
         pop       = 1'b1;
         state_d   = S_START;
         tx_d      = 1'b0;
         cnt_d     = '0;
         div_d     = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
         dbits_d   = cfg_dbits;
         parity_d  = cfg_parity;
         stop2_d   = cfg_stop2;
         par_bit_d = head_par;
         shreg_d   = head;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= S_IDLE;
         div_q     <= DIV_W'(2);
         cnt_q     <= '0;
         dbits_q   <= 2'b11;
         parity_q  <= 2'b00;
         stop2_q   <= 1'b0;
         par_bit_q <= 1'b0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         dbits_q   <= dbits_d;
         parity_q  <= parity_d;
         stop2_q   <= stop2_d;
         par_bit_q <= par_bit_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
      end
   end

   assign tx_serial = tx_q;
   assign tx_done   = done_q;
   assign tx_busy   = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule
